// File: rtl/vm_multi.sv
`default_nettype none
// ============================================================================
// Module      : vm_multi
// Description : Multi-coin, multi-product vending controller with greedy
//               one-coin-per-cycle change. Optional stock tracking: VM_STOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vm_multi #(
    parameter int                          NCOIN      = 3,
    parameter int                          CREDIT_W   = 8,
    parameter logic [NCOIN*CREDIT_W-1:0]   COIN_VALS  = {8'd10, 8'd5, 8'd1},
    parameter int                          NPROD      = 4,
    parameter logic [NPROD*CREDIT_W-1:0]   PRICES     = {8'd15, 8'd12, 8'd8, 8'd3},
    parameter int                          CREDIT_MAX = 99,
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 15,
    localparam int                         SEL_W      = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCOIN-1:0]     coin,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 buy,
    input  logic                 giveup,
    input  logic                 refill,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 drink_valid,
    output logic [SEL_W-1:0]     drink_id,
    output logic [NCOIN-1:0]     change_coin,
    output logic                 coin_reject,
    output logic                 deny,
    output logic                 busy,
    output logic [NPROD-1:0]     sold_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;

    localparam logic [CREDIT_W:0] C_CREDIT_MAX = (CREDIT_W+1)'(CREDIT_MAX);

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_drink_valid;
    logic [SEL_W-1:0]    r_drink_id;
    logic [NCOIN-1:0]    r_change_coin;
    logic                r_coin_reject;
    logic                r_deny;
    logic                r_busy;

    logic [NCOIN-1:0]    r_coin_q;
    logic                r_buy_q;
    logic                r_giveup_q;

    logic [NCOIN-1:0]    w_coin_edge;
    logic                w_buy_edge;
    logic                w_giveup_edge;
    logic                w_coin_multi;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_fits;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_ok;
    logic                w_stock_ok;
    logic                w_buy_ok;
    logic                w_vend_fire;
    logic [CREDIT_W-1:0] w_chg_val;
    logic [NCOIN-1:0]    w_chg_onehot;
    logic [NPROD-1:0]    w_sold_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_coin_q   <= '0;
            r_buy_q    <= 1'b0;
            r_giveup_q <= 1'b0;
        end else begin
            r_coin_q   <= coin;
            r_buy_q    <= buy;
            r_giveup_q <= giveup;
        end
    end

    assign w_coin_edge   = coin & ~r_coin_q;
    assign w_buy_edge    = buy & ~r_buy_q;
    assign w_giveup_edge = giveup & ~r_giveup_q;
    assign w_coin_multi  = |(w_coin_edge & (w_coin_edge - NCOIN'(1)));

    always_comb begin
        w_coin_val = '0;
        for (int k = 0; k < NCOIN; k++) begin
            if (w_coin_edge[k]) w_coin_val = w_coin_val | COIN_VALS[k*CREDIT_W +: CREDIT_W];
        end
    end

    // Widened by one bit so credit+coin can never wrap before the limit check.
    assign w_coin_sum  = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_fits = (w_coin_sum <= C_CREDIT_MAX);

    always_comb begin
        w_price  = '0;
        w_sel_ok = 1'b0;
        for (int p = 0; p < NPROD; p++) begin
            if (sel == SEL_W'(p)) begin
                w_price  = PRICES[p*CREDIT_W +: CREDIT_W];
                w_sel_ok = 1'b1;
            end
        end
    end

    // Ascending scan: the last qualifying slot is the largest coin that fits.
    always_comb begin
        w_chg_val    = '0;
        w_chg_onehot = '0;
        for (int k = 0; k < NCOIN; k++) begin
            if (COIN_VALS[k*CREDIT_W +: CREDIT_W] <= r_credit) begin
                w_chg_val    = COIN_VALS[k*CREDIT_W +: CREDIT_W];
                w_chg_onehot = NCOIN'(1) << k;
            end
        end
    end

    assign w_buy_ok    = w_sel_ok && w_stock_ok && (r_credit >= w_price);
    assign w_vend_fire = (r_state == S_IDLE) && !w_giveup_edge && w_buy_edge && w_buy_ok;

`ifdef VM_STOCK_EN
    generate
        for (genvar p = 0; p < NPROD; p++) begin : g_stock
            logic [STOCK_W-1:0] r_cnt;
            logic               r_empty;

            always_ff @(posedge clk) begin
                if (rst || refill) begin
                    r_cnt   <= STOCK_W'(STOCK_INIT);
                    r_empty <= (STOCK_INIT == 0);
                end else if (w_vend_fire && (sel == SEL_W'(p))) begin
                    r_cnt   <= r_cnt - STOCK_W'(1);
                    r_empty <= (r_cnt == STOCK_W'(1));
                end
            end

            assign w_sold_out[p] = r_empty;
        end
    endgenerate

    always_comb begin
        w_stock_ok = 1'b0;
        for (int p = 0; p < NPROD; p++) begin
            if (sel == SEL_W'(p)) w_stock_ok = !w_sold_out[p];
        end
    end
`else
    logic w_unused_stock;
    assign w_unused_stock = refill ^ (STOCK_W > 0) ^ (STOCK_INIT > 0);
    assign w_sold_out     = '0;
    assign w_stock_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_drink_valid <= 1'b0;
            r_drink_id    <= '0;
            r_change_coin <= '0;
            r_coin_reject <= 1'b0;
            r_deny        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_drink_valid <= 1'b0;
            r_change_coin <= '0;
            r_coin_reject <= 1'b0;
            r_deny        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_giveup_edge) begin
                        r_coin_reject <= |w_coin_edge;
                        if (r_credit != '0) begin
                            r_state <= S_CHANGE;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_buy_edge) begin
                        r_coin_reject <= |w_coin_edge;
                        if (w_buy_ok) begin
                            r_credit      <= r_credit - w_price;
                            r_drink_id    <= sel;
                            r_drink_valid <= 1'b1;
                            r_state       <= S_VEND;
                            r_busy        <= 1'b1;
                        end else begin
                            r_deny <= 1'b1;
                        end
                    end else if (|w_coin_edge) begin
                        if (!w_coin_multi && w_coin_fits) r_credit <= w_coin_sum[CREDIT_W-1:0];
                        else                              r_coin_reject <= 1'b1;
                    end
                end
                // The VEND clock already ejects the first change coin.
                S_VEND, S_CHANGE: begin
                    r_coin_reject <= |w_coin_edge;
                    if (r_credit != '0) begin
                        r_change_coin <= w_chg_onehot;
                        r_credit      <= r_credit - w_chg_val;
                        if (r_credit == w_chg_val) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_CHANGE;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign credit      = r_credit;
    assign drink_valid = r_drink_valid;
    assign drink_id    = r_drink_id;
    assign change_coin = r_change_coin;
    assign coin_reject = r_coin_reject;
    assign deny        = r_deny;
    assign busy        = r_busy;
    assign sold_out    = w_sold_out;

endmodule
`default_nettype wire
